// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the instruction prefetch queue.
package core_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {REQ, WAIT, DRAIN, HALT} ifq_state_t;
  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry circular buffer of fetched words; flush wins over push and pop.
module ifq_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  ifq_entry_t din,
  output ifq_entry_t dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  ifq_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk_i)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: Wishbone-classic instruction prefetcher feeding IF/ID through a DEPTH-entry queue.
// Define IFQ_BYPASS_EN to forward an ack straight to the outputs when the queue is empty.
module ifetch_queue
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        e_fetch_err_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [31:0] wbm_addr_o
);
  ifq_state_t state;
  ifq_entry_t head, din;
  logic [31:0] pc;
  logic done, push, full, empty, byp;
  assign done = wbm_ack_i || wbm_err_i;
`ifdef IFQ_BYPASS_EN
  assign byp = state == WAIT && empty && !redirect_i && wbm_ack_i && !wbm_err_i;
`else
  assign byp = 1'b0;
`endif
  // A bypassed word that IF/ID takes immediately never enters the queue
  assign push = state == WAIT && done && !redirect_i && !(byp && !stall_i);
  assign din  = '{err: wbm_err_i, pc: wbm_addr_o, inst: wbm_err_i ? NOP_INST : wbm_dat_i};
  assign wbm_stb_o     = wbm_cyc_o;
  assign valid_o       = !empty || byp;
  assign instruction_o = byp ? wbm_dat_i : empty ? NOP_INST : head.inst;
  assign pc_o          = byp ? wbm_addr_o : head.pc;
  assign e_fetch_err_o = !empty && head.err;
  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (!stall_i),
    .flush (redirect_i),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // Bus address is latched separately so a redirect during DRAIN cannot disturb the open cycle
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state      <= REQ;
      pc         <= RESET_ADDR;
      wbm_cyc_o  <= 1'b0;
      wbm_addr_o <= RESET_ADDR;
    end else if (redirect_i) begin
      pc <= {redirect_addr_i[31:2], 2'b00};
      if ((state == WAIT || state == DRAIN) && !done) state <= DRAIN;
      else begin
        state     <= REQ;
        wbm_cyc_o <= 1'b0;
      end
    end else
      case (state)
        REQ: if (!full) begin
          wbm_cyc_o  <= 1'b1;
          wbm_addr_o <= pc;
          state      <= WAIT;
        end
        WAIT: if (wbm_err_i) begin
          wbm_cyc_o <= 1'b0;
          state     <= HALT;
        end else if (wbm_ack_i) begin
          wbm_cyc_o <= 1'b0;
          pc        <= pc + 32'd4;
          state     <= REQ;
        end
        DRAIN: if (done) begin
          wbm_cyc_o <= 1'b0;
          state     <= REQ;
        end
        HALT: ;
      endcase
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: random slave/stall/redirect stimulus against a queue-of-entries reference model.
module tb_ifetch_queue;
  import core_pkg::*;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_ADDR = 32'h8000_0000;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk_i = 1'b0, rst_i = 1'b1, redirect_i = 1'b0, stall_i = 1'b0;
  logic wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
  logic [31:0] redirect_addr_i = '0, wbm_dat_i = '0;
  logic valid_o, e_fetch_err_o, wbm_cyc_o, wbm_stb_o;
  logic [31:0] instruction_o, pc_o, wbm_addr_o;

  ifetch_queue #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .stall_i(stall_i), .valid_o(valid_o), .instruction_o(instruction_o), .pc_o(pc_o),
    .e_fetch_err_o(e_fetch_err_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .wbm_dat_i(wbm_dat_i), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_addr_o(wbm_addr_o)
  );

  always #5 clk_i = ~clk_i;

  ifq_entry_t model_q[$];
  int vectors = 0, miscompares = 0, pops = 0;
  bit exp_valid = 1'b0, in_rst = 1'b1;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_idle(string name);
    chk({name, "_cyc"}, 32'(wbm_cyc_o), 32'd0);
    chk({name, "_valid"}, 32'(valid_o), 32'd0);
    chk({name, "_err"}, 32'(e_fetch_err_o), 32'd0);
    chk({name, "_inst"}, instruction_o, NOP_INST);
  endtask

  function automatic logic [31:0] memw(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  // Stimulus and slave: decides this cycle's inputs and records what the DUT owes IF/ID
  initial begin
    logic busy, stale, halted, byp_now;
    logic [31:0] exp_addr, cur_addr;
    int wcnt, mode, pre;
    busy = 0; stale = 0; halted = 0; exp_addr = RESET_ADDR; cur_addr = '0; wcnt = 0; mode = 0;
    repeat (2) @(negedge clk_i);
    check_idle("reset");
    rst_i = 0;
    in_rst = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_i);
      if (c == 2000) begin
        rst_i = 1; in_rst = 1; redirect_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
        #1 check_idle("mid_reset");
        model_q.delete();
        busy = 0; stale = 0; halted = 0; exp_addr = RESET_ADDR;
        @(negedge clk_i);
        rst_i = 0; in_rst = 0; exp_valid = 0;
        continue;
      end
      if (c % 64 == 0) mode = $urandom_range(0, 2);
      stall_i = mode == 1 ? 1'b1 : mode == 0 ? ($urandom_range(0, 9) == 0) : 1'($urandom_range(0, 1));
      redirect_i = $urandom_range(0, 39) == 0;
      if (redirect_i)
        case ($urandom_range(0, 2))
          0: redirect_addr_i = 32'h8000_0100 | $urandom_range(0, 255);
          1: redirect_addr_i = 32'hFFFF_FFF0 | $urandom_range(0, 15);
          default: redirect_addr_i = $urandom;
        endcase
      wbm_ack_i = 0;
      wbm_err_i = 0;
      pre = model_q.size();
      byp_now = 0;
      if (wbm_cyc_o) begin
        if (!busy) begin
          busy = 1;
          cur_addr = wbm_addr_o;
          wcnt = $urandom_range(0, 3);
          chk("req_addr", wbm_addr_o, exp_addr);
          chk("req_while_halted", 32'(halted), 32'd0);
          chk("req_when_full", 32'(model_q.size() < DEPTH), 32'd1);
        end else chk("addr_hold", wbm_addr_o, cur_addr);
        chk("stb", 32'(wbm_stb_o), 32'd1);
        if (wcnt == 0) begin
          busy = 0;
          if ($urandom_range(0, 19) == 0) wbm_err_i = 1;
          else begin
            wbm_ack_i = 1;
            wbm_dat_i = memw(cur_addr);
          end
          if (!redirect_i && !stale) begin
            model_q.push_back('{err: wbm_err_i, pc: cur_addr, inst: wbm_err_i ? NOP_INST : wbm_dat_i});
            if (wbm_err_i) halted = 1;
            else begin
              exp_addr = cur_addr + 32'd4;
              byp_now = BYP && pre == 0;
            end
          end
          stale = 0;
        end else begin
          wcnt--;
          if (redirect_i) stale = 1;
        end
      end
      if (redirect_i) begin
        model_q.delete();
        exp_addr = {redirect_addr_i[31:2], 2'b00};
        halted = 0;
      end
      exp_valid = pre != 0 || byp_now;
    end
    @(negedge clk_i);
    chk("pops_seen", 32'(pops > 100), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: compares what IF/ID consumes against the scoreboard head
  initial begin
    ifq_entry_t e;
    forever begin
      @(negedge clk_i);
      #1;
      if (in_rst) continue;
      chk("valid", 32'(valid_o), 32'(exp_valid));
      if (!valid_o) chk("nop_when_idle", instruction_o, NOP_INST);
      else if (!stall_i && !redirect_i) begin
        if (model_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pop_empty: got pc %h with no entry expected at %0t", pc_o, $time);
        end else begin
          e = model_q.pop_front();
          pops++;
          chk("pc", pc_o, e.pc);
          chk("inst", instruction_o, e.inst);
          chk("fetch_err", 32'(e_fetch_err_o), 32'(e.err));
        end
      end
    end
  end
endmodule
